// File: rtl/neuron_pkg.sv
// Shared constants, pipeline tag and saturating adder for the neuron MAC datapath.
package neuron_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 2 * DATA_W;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Per-sample control travelling alongside the data pipeline
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // Two's-complement add that clamps instead of wrapping
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    s = a + b;
    if (!a[ACC_W-1] && !b[ACC_W-1] && s[ACC_W-1]) return ACC_MAX;
    if (a[ACC_W-1] && b[ACC_W-1] && !s[ACC_W-1]) return ACC_MIN;
    return s;
  endfunction

endpackage

// File: rtl/neuron_mac_weight_mem.sv
// Single-port-write, synchronous-read weight store; reads return pre-write data.
module neuron_mac_weight_mem #(
  parameter int unsigned depth     = 784,
  parameter int unsigned width     = 16,
  parameter int unsigned addrWidth = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addrWidth-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [addrWidth-1:0] raddr,
  output logic [width-1:0]     rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: streams inputs against stored weights, adds bias,
// emits one saturated sum per frame with a single-cycle valid pulse.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int unsigned numWeight = 784,
  parameter int unsigned dataWidth = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_en,
  input  logic [$clog2(numWeight)-1:0]  w_addr,
  input  logic [dataWidth-1:0]          w_data,
  input  logic                          b_en,
  input  logic [2*dataWidth-1:0]        b_data,
  input  logic [dataWidth-1:0]          in_data,
  input  logic                          in_valid,
  output logic [2*dataWidth-1:0]        sum,
  output logic                          sum_valid
);

  localparam int unsigned addressWidth = $clog2(numWeight);

  logic [addressWidth-1:0] rd_cnt;
  logic                    rd_last_c;
  logic [DATA_W-1:0]       w_rd;
  logic [DATA_W-1:0]       d_q;
  logic [ACC_W-1:0]        prod;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        bias;
  tag_t                    s0_tag;
  tag_t                    s1_tag;
  logic                    s2_last;

  assign rd_last_c = (rd_cnt == addressWidth'(numWeight - 1));

  neuron_mac_weight_mem #(
    .depth    (numWeight),
    .width    (DATA_W),
    .addrWidth(addressWidth)
  ) u_weight_mem (
    .clk  (clk),
    .we   (w_en),
    .waddr(w_addr),
    .wdata(w_data),
    .raddr(rd_cnt),
    .rdata(w_rd)
  );

  // Datapath registers with no reset; qualified by the tag pipeline
  always_ff @(posedge clk) begin
    d_q  <= in_data;
    prod <= {{DATA_W{d_q[DATA_W-1]}}, d_q} * {{DATA_W{w_rd[DATA_W-1]}}, w_rd};
  end

  // Control, accumulator and output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      s0_tag    <= '0;
      s1_tag    <= '0;
      s2_last   <= 1'b0;
      acc       <= '0;
      bias      <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      if (in_valid) rd_cnt <= rd_last_c ? '0 : rd_cnt + addressWidth'(1);
      s0_tag.valid <= in_valid;
      s0_tag.first <= in_valid && (rd_cnt == '0);
      s0_tag.last  <= in_valid && rd_last_c;
      s1_tag       <= s0_tag;
      // First product of a frame restarts the running sum
      if (s1_tag.valid) acc <= s1_tag.first ? prod : sat_add(acc, prod);
      s2_last <= s1_tag.valid && s1_tag.last;
      if (b_en) bias <= b_data;
      sum_valid <= s2_last;
      if (s2_last) sum <= sat_add(acc, bias);
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a 4-weight configuration.
module tb_neuron_mac;

  localparam int unsigned NW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [1:0]  w_addr;
  logic [15:0] w_data;
  logic        b_en;
  logic [31:0] b_data;
  logic [15:0] in_data;
  logic        in_valid;
  logic [31:0] sum;
  logic        sum_valid;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int drive_cyc  = 0;
  int pulse_cnt  = 0;
  logic [31:0] psum [$];
  int          pcyc [$];

  neuron_mac #(.numWeight(NW), .dataWidth(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_en     (b_en),
    .b_data   (b_data),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sum      (sum),
    .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sum_valid === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      psum.push_back(sum);
      pcyc.push_back(cyc);
    end
  end

  task automatic step(input logic v, input logic [15:0] d, input logic we,
                      input logic [1:0] wa, input logic [15:0] wd);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    w_en     = we;
    w_addr   = wa;
    w_data   = wd;
    if (v) drive_cyc = cyc;
  endtask

  task automatic load_weights(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
    step(1'b0, 16'd0, 1'b1, 2'd0, w0);
    step(1'b0, 16'd0, 1'b1, 2'd1, w1);
    step(1'b0, 16'd0, 1'b1, 2'd2, w2);
    step(1'b0, 16'd0, 1'b1, 2'd3, w3);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic load_bias(input logic [31:0] b);
    @(negedge clk);
    b_en   = 1'b1;
    b_data = b;
    @(negedge clk);
    b_en   = 1'b0;
  endtask

  task automatic frame(input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    step(1'b1, d0, 1'b0, 2'd0, 16'd0);
    step(1'b1, d1, 1'b0, 2'd0, 16'd0);
    step(1'b1, d2, 1'b0, 2'd0, 16'd0);
    step(1'b1, d3, 1'b0, 2'd0, 16'd0);
  endtask

  task automatic wait_pulses(input int target, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (pulse_cnt >= target) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (sum !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_sum: got %h expected %h", sum, 32'd0);
    end
    compared++;
    if (sum_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_valid: got %b expected 0", sum_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int base;
    bit got;
    load_weights(16'd1, 16'd2, 16'd3, 16'd4);
    load_bias(32'd5);
    base = pulse_cnt;
    frame(16'd10, 16'd20, 16'd30, 16'd40);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
    wait_pulses(base + 1, got);
    compared++;
    if (!got || psum[base] !== 32'd305) begin
      mismatched++;
      $display("FAIL basic_sum: got %0d (pulse %0b) expected 305", got ? psum[base] : sum, got);
    end
    compared++;
    if (!got || (pcyc[base] - drive_cyc) != 4) begin
      mismatched++;
      $display("FAIL basic_latency: got %0d expected 4", got ? pcyc[base] - drive_cyc : -1);
    end
    repeat (6) @(negedge clk);
    #1;
    compared++;
    if (pulse_cnt != base + 1) begin
      mismatched++;
      $display("FAIL basic_one_pulse: got %0d pulses expected 1", pulse_cnt - base);
    end
  endtask

  task automatic test_pos_overflow;
    int base;
    bit got;
    load_weights(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    load_bias(32'd1);
    base = pulse_cnt;
    frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
    wait_pulses(base + 1, got);
    compared++;
    if (!got || psum[base] !== 32'h7FFFFFFF) begin
      mismatched++;
      $display("FAIL pos_sat: got %h expected 7fffffff", got ? psum[base] : sum);
    end
  endtask

  task automatic test_neg_overflow;
    int base;
    bit got;
    load_weights(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    load_bias(32'hFFFFFFFF);
    base = pulse_cnt;
    frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
    wait_pulses(base + 1, got);
    compared++;
    if (!got || psum[base] !== 32'h80000000) begin
      mismatched++;
      $display("FAIL neg_sat: got %h expected 80000000", got ? psum[base] : sum);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    bit got;
    load_weights(16'd1, 16'd2, 16'd3, 16'd4);
    load_bias(32'd0);
    base = pulse_cnt;
    frame(16'd1, 16'd1, 16'd1, 16'd1);
    step(1'b1, 16'd2, 1'b0, 2'd0, 16'd0);
    step(1'b0, 16'd9, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd0, 1'b0, 2'd0, 16'd0);
    step(1'b0, 16'd9, 1'b0, 2'd0, 16'd0);
    step(1'b0, 16'd9, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd0, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd2, 1'b0, 2'd0, 16'd0);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
    wait_pulses(base + 2, got);
    repeat (4) @(negedge clk);
    #1;
    compared++;
    if (!got || pulse_cnt != base + 2) begin
      mismatched++;
      $display("FAIL b2b_pulses: got %0d expected 2", pulse_cnt - base);
    end
    compared++;
    if (pulse_cnt < base + 1 || psum[base] !== 32'd10) begin
      mismatched++;
      $display("FAIL b2b_frame_a: got %0d expected 10", pulse_cnt > base ? psum[base] : 0);
    end
    compared++;
    if (pulse_cnt < base + 2 || psum[base+1] !== 32'd10) begin
      mismatched++;
      $display("FAIL b2b_frame_b: got %0d expected 10", pulse_cnt > base + 1 ? psum[base+1] : 0);
    end
  endtask

  task automatic test_mid_reset;
    int base;
    bit got;
    load_bias(32'd7);
    base = pulse_cnt;
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    compared++;
    if (pulse_cnt != base) begin
      mismatched++;
      $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulse_cnt - base);
    end
    compared++;
    if (sum !== 32'd0) begin
      mismatched++;
      $display("FAIL abort_sum_cleared: got %0d expected 0", sum);
    end
    frame(16'd1, 16'd1, 16'd1, 16'd1);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
    wait_pulses(base + 1, got);
    compared++;
    if (!got || psum[base] !== 32'd10) begin
      mismatched++;
      $display("FAIL abort_next_frame: got %0d expected 10", got ? psum[base] : sum);
    end
  endtask

  task automatic test_weight_write;
    int base;
    bit got;
    base = pulse_cnt;
    // weight[3] rewritten while input 1 is streaming; used by input 3
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd1, 1'b1, 2'd3, 16'd100);
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    // weight[0] rewritten in the cycle it is read: old value this frame
    step(1'b1, 16'd1, 1'b1, 2'd0, 16'd50);
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    step(1'b1, 16'd1, 1'b0, 2'd0, 16'd0);
    frame(16'd1, 16'd1, 16'd1, 16'd1);
    step(1'b0, 16'd0, 1'b0, 2'd0, 16'd0);
    wait_pulses(base + 3, got);
    compared++;
    if (pulse_cnt < base + 1 || psum[base] !== 32'd106) begin
      mismatched++;
      $display("FAIL wr_midframe: got %0d expected 106", pulse_cnt > base ? psum[base] : 0);
    end
    compared++;
    if (pulse_cnt < base + 2 || psum[base+1] !== 32'd106) begin
      mismatched++;
      $display("FAIL wr_read_first: got %0d expected 106", pulse_cnt > base + 1 ? psum[base+1] : 0);
    end
    compared++;
    if (!got || psum[base+2] !== 32'd155) begin
      mismatched++;
      $display("FAIL wr_next_frame: got %0d expected 155", pulse_cnt > base + 2 ? psum[base+2] : 0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    w_en     = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    b_en     = 1'b0;
    b_data   = '0;
    in_data  = '0;
    in_valid = 1'b0;
    test_reset();
    test_basic();
    test_pos_overflow();
    test_neg_overflow();
    test_back_to_back();
    test_mid_reset();
    test_weight_write();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
